// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame-buffer geometry and 3-bit colour codes.
// Used by the frame sink and by the draw logic that feeds it.
package vga_pkg;

    localparam int WIDTH   = 320;
    localparam int HEIGHT  = 240;
    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 17;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;

    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    typedef enum logic [2:0] {
        BLACK   = 3'b000,
        BLUE    = 3'b001,
        GREEN   = 3'b010,
        CYAN    = 3'b011,
        RED     = 3'b100,
        MAGENTA = 3'b101,
        YELLOW  = 3'b110,
        WHITE   = 3'b111
    } colour_t;

    // Expand a {R,G,B} code to full-scale 8-bit DAC channels.
    function automatic logic [23:0] colour_to_rgb(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read-before-write on a shared address; coded for block-RAM inference.
module frame_ram import vga_pkg::*; #(
    parameter int DEPTH = WIDTH * HEIGHT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [2:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [2:0]    rdata_o
);

    logic [2:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/vga_frame_sink.sv
// Pixel-write sink: stores (x, y, colour) writes and scans them out as VGA,
// each stored pixel doubled in X and Y, with frame timing reported back.
module vga_frame_sink #(
    parameter int WIDTH   = vga_pkg::WIDTH,
    parameter int HEIGHT  = vga_pkg::HEIGHT,
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] x_in,
    input  logic [8:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       plot,
    output logic       write_drop,
    output logic       frame_start,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);
    import vga_pkg::*;

    localparam int AW    = $clog2(WIDTH * HEIGHT);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);
    localparam logic [9:0] V_PRE   = 10'(V_VIS - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
    localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_HALF = 8'(CLK_DIV / 2);

    logic [7:0]    div_q, div_d;
    logic          vga_clk_q, vga_clk_d;
    logic [9:0]    hcount_q, hcount_d;
    logic [9:0]    vcount_q, vcount_d;
    logic          pix_en, vis_raw, hs_raw, vs_raw;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          vis1_q, hs1_q, vs1_q;
    logic          blank_n_q, hs_q, vs_q;
    logic          frame_start_q, frame_start_d;
    logic          write_drop_q, write_drop_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [2:0]    rdata;

    always_comb begin
        pix_en    = (div_q == DIV_LAST);
        div_d     = pix_en ? 8'd0 : div_q + 8'd1;
        // Pixel clock rises halfway through each pixel period.
        vga_clk_d = (div_d >= DIV_HALF);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 10'd0;
                vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
            end
        end

        vis_raw = (hcount_q < H_VIS_L) && (vcount_q < V_VIS_L);
        hs_raw  = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
        vs_raw  = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
        // Blanked positions would address past the buffer; park the read at 0.
        rd_addr_d = vis_raw ? AW'(vcount_q[9:1] * WIDTH + hcount_q[9:1]) : '0;

        frame_start_d = pix_en && (hcount_q == H_LAST) && (vcount_q == V_PRE);

        we           = plot && (x_in < WIDTH_L) && (y_in < HEIGHT_L);
        write_drop_d = plot && !we;
        waddr        = AW'(y_in * WIDTH + x_in);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            vga_clk_q     <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            rd_addr_q     <= '0;
            vis1_q        <= 1'b0;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            write_drop_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            vga_clk_q     <= vga_clk_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            frame_start_q <= frame_start_d;
            write_drop_q  <= write_drop_d;
            if (pix_en) begin
                rd_addr_q <= rd_addr_d;
                vis1_q    <= vis_raw;
                hs1_q     <= hs_raw;
                vs1_q     <= vs_raw;
                blank_n_q <= vis1_q;
                hs_q      <= hs1_q;
                vs_q      <= vs1_q;
            end
        end
    end

    frame_ram #(
        .DEPTH (WIDTH * HEIGHT),
        .AW    (AW)
    ) u_frame_ram (
        .clk_i   (clock),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (colour_in),
        .re_i    (pix_en),
        .raddr_i (rd_addr_q),
        .rdata_o (rdata)
    );

    assign {vga_r, vga_g, vga_b} = blank_n_q ? colour_to_rgb(rdata) : 24'd0;

    assign write_drop  = write_drop_q;
    assign frame_start = frame_start_q;
    assign vga_clk     = vga_clk_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_frame_sink.sv
// Directed bench for vga_frame_sink on a shrunken geometry (16x8 buffer,
// 48x22 VGA frame) so several whole frames fit in a short run.
module tb_vga_frame_sink;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] x_in = '0;
    logic [8:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       plot = 1'b0;
    logic       write_drop, frame_start, vga_clk, vga_hs, vga_vs;
    logic       vga_blank_n, vga_sync_n;
    logic [7:0] vga_r, vga_g, vga_b;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fs_cnt = 0, hs_lo = 0, vs_lo = 0, bl_hi = 0;
    logic cnt_en = 1'b0;
    logic drop_seen;

    vga_frame_sink #(
        .WIDTH(16), .HEIGHT(8), .CLK_DIV(2),
        .H_VIS(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(16), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clock(clock), .reset(reset), .x_in(x_in), .y_in(y_in),
        .colour_in(colour_in), .plot(plot), .write_drop(write_drop),
        .frame_start(frame_start), .vga_clk(vga_clk), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cnt_en) begin
            if (frame_start) fs_cnt++;
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (vga_blank_n) bl_hi++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // cyc counts rising edges since the last reset release; return 1 time unit after edge k.
    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clock);
            cyc++;
        end
        #1;
    endtask

    task automatic write_px(input int x, input int y, input logic [2:0] c);
        x_in = 9'(x);
        y_in = 9'(y);
        colour_in = c;
        plot = 1'b1;
        @(posedge clock);
        cyc++;
        #1;
        plot = 1'b0;
    endtask

    // VGA pixel (X,Y) of frame f is on the pins for edges 2n+4..2n+5, n = linear counter index.
    function automatic int kpix(input int f, input int vx, input int vy);
        return 2 * (f * 1056 + vy * 48 + vx) + 5;
    endfunction

    task automatic pix(input string tag, input int k, input logic [2:0] c);
        wait_cyc(k);
        chk(tag, 32'({vga_r, vga_g, vga_b}), 32'({{8{c[2]}}, {8{c[1]}}, {8{c[0]}}}));
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_blank", 32'(vga_blank_n), 32'd0);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_clk", 32'(vga_clk), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_drop", 32'(write_drop), 32'd0);
        chk("sync_n", 32'(vga_sync_n), 32'd0);
        #2;
        reset = 1'b0;
        cyc = 0;
        cnt_en = 1'b1;

        write_px(0, 0, 3'b100);
        write_px(15, 7, 3'b011);
        write_px(15, 5, 3'b010);
        write_px(5, 7, 3'b001);
        write_px(0, 6, 3'b111);
        chk("drop_legal", 32'(write_drop), 32'd0);
        write_px(16, 5, 3'b100);
        chk("drop_x", 32'(write_drop), 32'd1);
        write_px(5, 8, 3'b100);
        chk("drop_y", 32'(write_drop), 32'd1);
        @(posedge clock);
        cyc++;
        #1;
        chk("drop_clear", 32'(write_drop), 32'd0);
        write_px(10, 2, 3'b010);
        drop_seen = 1'b0;
        for (int x = 0; x < 16; x++) begin
            write_px(x, 3, 3'(x));
            drop_seen = drop_seen | write_drop;
        end
        chk("row_nodrop", 32'(drop_seen), 32'd0);

        wait_cyc(75);   chk("hs_pre", 32'(vga_hs), 32'd1);
                        chk("vclk_hi", 32'(vga_clk), 32'd1);
        wait_cyc(76);   chk("hs_first", 32'(vga_hs), 32'd0);
                        chk("vclk_lo", 32'(vga_clk), 32'd0);
        wait_cyc(91);   chk("hs_last", 32'(vga_hs), 32'd0);
        wait_cyc(92);   chk("hs_post", 32'(vga_hs), 32'd1);
        wait_cyc(99);   chk("blank_pre", 32'(vga_blank_n), 32'd0);
        wait_cyc(100);  chk("blank_first", 32'(vga_blank_n), 32'd1);
        wait_cyc(163);  chk("blank_last", 32'(vga_blank_n), 32'd1);
        wait_cyc(164);  chk("blank_post", 32'(vga_blank_n), 32'd0);
        wait_cyc(1535); chk("fs_pre", 32'(frame_start), 32'd0);
        wait_cyc(1536); chk("fs_pulse", 32'(frame_start), 32'd1);
        wait_cyc(1537); chk("fs_post", 32'(frame_start), 32'd0);
        wait_cyc(1731); chk("vs_pre", 32'(vga_vs), 32'd1);
        wait_cyc(1732); chk("vs_first", 32'(vga_vs), 32'd0);
        wait_cyc(1923); chk("vs_last", 32'(vga_vs), 32'd0);
        wait_cyc(1924); chk("vs_post", 32'(vga_vs), 32'd1);

        wait_cyc(2112);
        cnt_en = 1'b0;
        chk("fs_per_frame", 32'(fs_cnt), 32'd1);
        chk("hs_low_clks", 32'(hs_lo), 32'd352);
        chk("vs_low_clks", 32'(vs_lo), 32'd192);
        chk("vis_clks", 32'(bl_hi), 32'd1024);

        pix("px_0_0", kpix(1, 0, 0), 3'b100);
        pix("px_1_1", kpix(1, 1, 1), 3'b100);
        for (int x = 0; x < 16; x++) begin
            pix("row3", kpix(1, 2 * x, 6), 3'(x));
        end
        pix("keep_15_5", kpix(1, 30, 10), 3'b010);
        pix("alias_0_6", kpix(1, 0, 12), 3'b111);
        pix("keep_5_7", kpix(1, 10, 14), 3'b001);
        pix("px_30_14", kpix(1, 30, 14), 3'b011);
        pix("px_31_15", kpix(1, 31, 15), 3'b011);

        // Overwrite (10,2) on the very edge the scan reads it for VGA (20,4).
        wait_cyc(4651);
        write_px(10, 2, 3'b101);
        pix("rbw_old", kpix(2, 20, 4), 3'b010);
        pix("rbw_next_px", kpix(2, 21, 4), 3'b101);
        pix("rbw_next_frame", kpix(3, 20, 4), 3'b101);

        wait_cyc(9072);
        chk("mid_blank", 32'(vga_blank_n), 32'd1);
        chk("mid_rgb", 32'({vga_r, vga_g, vga_b}), 32'h00FFFF);
        reset = 1'b1;
        #1;
        chk("arst_hs", 32'(vga_hs), 32'd1);
        chk("arst_vs", 32'(vga_vs), 32'd1);
        chk("arst_blank", 32'(vga_blank_n), 32'd0);
        chk("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        cyc = 0;

        pix("kept_0_0", kpix(0, 0, 0), 3'b100);
        wait_cyc(75);   chk("r_hs_pre", 32'(vga_hs), 32'd1);
        wait_cyc(76);   chk("r_hs_first", 32'(vga_hs), 32'd0);
        pix("kept_30_14", kpix(0, 30, 14), 3'b011);
        wait_cyc(1536); chk("r_fs_pulse", 32'(frame_start), 32'd1);
        wait_cyc(1731); chk("r_vs_pre", 32'(vga_vs), 32'd1);
        wait_cyc(1732); chk("r_vs_first", 32'(vga_vs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
